// File: rtl/vga_sprite_overlay_if.sv
// Command handshake from the keyboard/button front end to the sprite overlay.
// A command transfers on a clk where cmd_valid && cmd_ready; cmd_err flags a rejected one.
interface vga_sprite_overlay_if #(
    parameter int ID_W = 2
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [ID_W-1:0] cmd_id;
    logic [2:0]      cmd_op;
    logic [7:0]      cmd_arg;
    logic            cmd_err;

    modport master (output cmd_valid, cmd_id, cmd_op, cmd_arg, input cmd_ready, cmd_err);
    modport slave  (input cmd_valid, cmd_id, cmd_op, cmd_arg, output cmd_ready, cmd_err);
endinterface

// File: rtl/vga_sprite_overlay.sv
// Multi-sprite 1-bit glyph overlay on the VGA pixel path: two-stage pixel pipeline
// plus per-sprite live/shadow state that is committed only at the frame boundary.
module vga_sprite_overlay #(
    parameter int          NUM_SPRITES = 4,
    parameter int          SPRITE_W    = 50,
    parameter int          SPRITE_H    = 50,
    parameter int          GLYPH_FIRST = 33,
    parameter int          GLYPH_COUNT = 94,
    parameter int          SCREEN_W    = 640,
    parameter int          SCREEN_H    = 480,
    parameter logic [11:0] FG_COLOR    = 12'h000,
    parameter int          ID_W        = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
    parameter int          ROM_AW      = $clog2(GLYPH_COUNT * SPRITE_W * SPRITE_H)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_en,
    input  logic               screen_end,
    input  logic [9:0]         x,
    input  logic [8:0]         y,
    input  logic               active_in,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic [11:0]        bg_color,
    output logic [ROM_AW-1:0]  rom_addr,
    input  logic               rom_data,
    vga_sprite_overlay_if.slave cmd,
    output logic [11:0]        rgb,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               active_out
);
    localparam int MAX_X    = SCREEN_W - SPRITE_W;
    localparam int MAX_Y    = SCREEN_H - SPRITE_H;
    localparam int GLYPH_SZ = SPRITE_W * SPRITE_H;

    typedef enum logic [2:0] {
        OP_SET_GLYPH, OP_UP, OP_DOWN, OP_LEFT, OP_RIGHT, OP_ENABLE, OP_DISABLE, OP_HOME
    } op_e;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic [7:0] glyph;
        logic       en;
    } live_t;

    typedef struct packed {
        logic       up, dn, lf, rt, home;
        logic [7:0] glyph;
        logic       glyph_v;
        logic       en;
        logic       en_v;
    } pend_t;

    live_t live [NUM_SPRITES];
    live_t nxt  [NUM_SPRITES];
    pend_t pend [NUM_SPRITES];

    function automatic live_t reset_live(input int i);
        live_t s;
        int    px;
        px = i * SPRITE_W;
        if (px > MAX_X) px = MAX_X;
        s.x     = 10'(px);
        s.y     = '0;
        s.glyph = 8'(GLYPH_FIRST + (i % GLYPH_COUNT));
        s.en    = (i == 0);
        return s;
    endfunction

    // ---------------- command handshake ----------------
    logic boundary, accept, id_bad, arg_bad, cmd_ok;

    assign boundary      = pix_en && screen_end;
    assign cmd.cmd_ready = reset && !boundary;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign id_bad        = {1'b0, cmd.cmd_id} >= (ID_W + 1)'(NUM_SPRITES);
    assign arg_bad       = (op_e'(cmd.cmd_op) == OP_SET_GLYPH) &&
                           ((int'(cmd.cmd_arg) < GLYPH_FIRST) ||
                            (int'(cmd.cmd_arg) > GLYPH_FIRST + GLYPH_COUNT - 1));
    assign cmd_ok        = accept && !id_bad && !arg_bad;

    // Frame-boundary commit: HOME beats moves, opposite moves cancel, edges clamp.
    always_comb begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
            // NOTE: full default first so no path leaves nxt unassigned (no latch).
            nxt[i] = live[i];
            if (pend[i].home) begin
                nxt[i].x = reset_live(i).x;
                nxt[i].y = reset_live(i).y;
            end else begin
                if (pend[i].up && !pend[i].dn && live[i].y != '0)           nxt[i].y = live[i].y - 9'd1;
                if (pend[i].dn && !pend[i].up && int'(live[i].y) < MAX_Y)    nxt[i].y = live[i].y + 9'd1;
                if (pend[i].lf && !pend[i].rt && live[i].x != '0)           nxt[i].x = live[i].x - 10'd1;
                if (pend[i].rt && !pend[i].lf && int'(live[i].x) < MAX_X)    nxt[i].x = live[i].x + 10'd1;
            end
            if (pend[i].glyph_v) nxt[i].glyph = pend[i].glyph;
            if (pend[i].en_v)    nxt[i].en    = pend[i].en;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sprite state is a handful of flops, so it is reset explicitly, not left as RAM.
            for (int i = 0; i < NUM_SPRITES; i++) begin
                live[i] <= reset_live(i);
                pend[i] <= '0;
            end
            cmd.cmd_err <= 1'b0;
        end else begin
            cmd.cmd_err <= accept && (id_bad || arg_bad);
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (boundary) begin
                    live[i] <= nxt[i];
                    pend[i] <= '0;
                end else if (cmd_ok && int'(cmd.cmd_id) == i) begin
                    case (op_e'(cmd.cmd_op))
                        OP_SET_GLYPH: begin pend[i].glyph <= cmd.cmd_arg; pend[i].glyph_v <= 1'b1; end
                        OP_UP:        pend[i].up   <= 1'b1;
                        OP_DOWN:      pend[i].dn   <= 1'b1;
                        OP_LEFT:      pend[i].lf   <= 1'b1;
                        OP_RIGHT:     pend[i].rt   <= 1'b1;
                        OP_ENABLE:    begin pend[i].en <= 1'b1; pend[i].en_v <= 1'b1; end
                        OP_DISABLE:   begin pend[i].en <= 1'b0; pend[i].en_v <= 1'b1; end
                        OP_HOME:      pend[i].home <= 1'b1;
                        default:      ;
                    endcase
                end
            end
        end
    end

    // ---------------- pixel pipeline ----------------
    logic [9:0]             lx [NUM_SPRITES];
    logic [8:0]             ly [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] hit;
    logic                   hit_any;
    logic [ROM_AW-1:0]      addr_next;

    always_comb begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
            lx[i]  = x - live[i].x;
            ly[i]  = y - live[i].y;
            hit[i] = live[i].en && (x >= live[i].x) && (y >= live[i].y) &&
                     (int'(lx[i]) < SPRITE_W) && (int'(ly[i]) < SPRITE_H);
        end
    end

    // Scan high to low so the lowest-index hit is the last (winning) assignment.
    always_comb begin
        hit_any   = 1'b0;
        addr_next = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_any   = 1'b1;
                addr_next = ROM_AW'(int'(lx[i]) + SPRITE_W * int'(ly[i]) +
                                    GLYPH_SZ * (int'(live[i].glyph) - GLYPH_FIRST));
            end
        end
    end

    logic hit_q, act_q, hs_q, vs_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rom_addr   <= '0;
            hit_q      <= 1'b0;
            act_q      <= 1'b0;
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
            rgb        <= 12'h000;
            hsync_out  <= 1'b1;
            vsync_out  <= 1'b1;
            active_out <= 1'b0;
        end else if (pix_en) begin
            if (hit_any) rom_addr <= addr_next;
            hit_q      <= hit_any;
            act_q      <= active_in;
            hs_q       <= hsync_in;
            vs_q       <= vsync_in;
            rgb        <= !act_q ? 12'h000 : (hit_q && rom_data) ? FG_COLOR : bg_color;
            hsync_out  <= hs_q;
            vsync_out  <= vs_q;
            active_out <= act_q;
        end
    end
endmodule

// File: tb/tb_vga_sprite_overlay.sv
// Directed bench for vga_sprite_overlay: drives pixels and frame boundaries by hand
// and checks rom_addr / rgb / delayed syncs against hand-computed expectations.
module tb_vga_sprite_overlay;
    localparam logic [11:0] BG = 12'hABC;
    localparam logic [11:0] FG = 12'h000;
    localparam logic [2:0] OP_SET = 3'd0, OP_UP = 3'd1, OP_DOWN = 3'd2, OP_LEFT = 3'd3,
                           OP_RIGHT = 3'd4, OP_ENABLE = 3'd5, OP_DISABLE = 3'd6, OP_HOME = 3'd7;

    logic        clk = 1'b0;
    logic        reset, pix_en, screen_end;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        active_in, hsync_in, vsync_in;
    logic [11:0] bg_color;
    logic [17:0] rom_addr;
    logic        rom_data = 1'b0;
    logic [11:0] rgb;
    logic        hsync_out, vsync_out, active_out;

    int errors = 0;
    int checks = 0;

    vga_sprite_overlay_if #(.ID_W(2)) cmd_bus ();

    vga_sprite_overlay dut (
        .clk        (clk),
        .reset      (reset),
        .pix_en     (pix_en),
        .screen_end (screen_end),
        .x          (x),
        .y          (y),
        .active_in  (active_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .bg_color   (bg_color),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .cmd        (cmd_bus),
        .rgb        (rgb),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .active_out (active_out)
    );

    always #5 clk = ~clk;

    function automatic logic rom_bit(input logic [17:0] a);
        return a[0] ^ a[2] ^ a[5];
    endfunction

    always @(posedge clk) rom_data <= rom_bit(rom_addr);

    task automatic tick(input logic [9:0] tx, input logic [8:0] ty, input logic act,
                        input logic hs, input logic vs, input logic se, input logic [11:0] bg);
        @(negedge clk);
        x = tx; y = ty; active_in = act; hsync_in = hs; vsync_in = vs;
        screen_end = se; bg_color = bg; pix_en = 1'b1;
        @(negedge clk);
        pix_en = 1'b0; screen_end = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic boundary();
        @(negedge clk);
        x = 10'd1000; y = 9'd500; active_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        pix_en = 1'b1; screen_end = 1'b1;
        #1;
        checks++;
        if (cmd_bus.cmd_ready !== 1'b0) begin
            errors++; $display("FAIL boundary cmd_ready: got %b want 0", cmd_bus.cmd_ready);
        end
        @(negedge clk);
        pix_en = 1'b0; screen_end = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [1:0] id, input logic [2:0] op, input logic [7:0] arg,
                            input logic exp_err);
        @(negedge clk);
        cmd_bus.cmd_valid = 1'b1; cmd_bus.cmd_id = id; cmd_bus.cmd_op = op; cmd_bus.cmd_arg = arg;
        checks++;
        if (cmd_bus.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL cmd_ready op%0d: got %b want 1", op, cmd_bus.cmd_ready);
        end
        @(negedge clk);
        cmd_bus.cmd_valid = 1'b0;
        checks++;
        if (cmd_bus.cmd_err !== exp_err) begin
            errors++; $display("FAIL cmd_err op%0d id%0d arg%0d: got %b want %b", op, id, arg, cmd_bus.cmd_err, exp_err);
        end
        @(negedge clk);
        checks++;
        if (cmd_bus.cmd_err !== 1'b0) begin
            errors++; $display("FAIL cmd_err pulse width op%0d: got %b want 0", op, cmd_bus.cmd_err);
        end
    endtask

    // Pixel at S1 with hs=0/vs=0/active=1, then a dummy pixel with opposite flags carrying BG.
    task automatic probe(input string name, input logic [9:0] px, input logic [8:0] py,
                         input logic exp_hit, input logic [17:0] exp_addr);
        logic [17:0] prev;
        logic [17:0] want_addr;
        logic [11:0] want_rgb;
        prev = rom_addr;
        tick(px, py, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
        want_addr = exp_hit ? exp_addr : prev;
        checks++;
        if (rom_addr !== want_addr) begin
            errors++; $display("FAIL %s rom_addr: got %0d want %0d", name, rom_addr, want_addr);
        end
        tick(10'd1000, 9'd500, 1'b0, 1'b1, 1'b1, 1'b0, BG);
        want_rgb = (exp_hit && rom_bit(exp_addr)) ? FG : BG;
        checks++;
        if (rgb !== want_rgb) begin
            errors++; $display("FAIL %s rgb: got %h want %h", name, rgb, want_rgb);
        end
        checks++;
        if ({active_out, hsync_out, vsync_out} !== 3'b100) begin
            errors++; $display("FAIL %s act/hs/vs: got %b want 100", name, {active_out, hsync_out, vsync_out});
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (rgb !== 12'h000) begin errors++; $display("FAIL %s rgb: got %h want 000", name, rgb); end
        checks++;
        if (hsync_out !== 1'b1 || vsync_out !== 1'b1) begin
            errors++; $display("FAIL %s syncs: got %b%b want 11", name, hsync_out, vsync_out);
        end
        checks++;
        if (active_out !== 1'b0) begin errors++; $display("FAIL %s active_out: got %b want 0", name, active_out); end
        checks++;
        if (rom_addr !== 18'd0) begin errors++; $display("FAIL %s rom_addr: got %0d want 0", name, rom_addr); end
        checks++;
        if (cmd_bus.cmd_ready !== 1'b0 || cmd_bus.cmd_err !== 1'b0) begin
            errors++; $display("FAIL %s ready/err: got %b%b want 00", name, cmd_bus.cmd_ready, cmd_bus.cmd_err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_scan();
        probe("scan 10,3",   10'd10,  9'd3,  1'b1, 18'd160);
        probe("scan 49,49",  10'd49,  9'd49, 1'b1, 18'd2499);
        probe("scan 0,0",    10'd0,   9'd0,  1'b1, 18'd0);
        probe("scan spr1",   10'd50,  9'd0,  1'b0, 18'd0);
        probe("scan spr2",   10'd100, 9'd10, 1'b0, 18'd0);
        probe("scan 0,50",   10'd0,   9'd50, 1'b0, 18'd0);
        // Blanked pixel: rgb is forced to 0 regardless of bg_color.
        tick(10'd300, 9'd300, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
        tick(10'd1000, 9'd500, 1'b1, 1'b1, 1'b1, 1'b0, BG);
        checks++;
        if (rgb !== 12'h000 || active_out !== 1'b0) begin
            errors++; $display("FAIL blank rgb/active: got %h/%b want 000/0", rgb, active_out);
        end
    endtask

    task automatic test_one_move();
        send_cmd(2'd0, OP_RIGHT, 8'd0, 1'b0);
        send_cmd(2'd0, OP_RIGHT, 8'd0, 1'b0);
        send_cmd(2'd0, OP_RIGHT, 8'd0, 1'b0);
        send_cmd(2'd0, OP_DOWN,  8'd0, 1'b0);
        boundary();
        probe("move 3,1",   10'd3,  9'd1,  1'b1, 18'd2);
        probe("move 0,0",   10'd0,  9'd0,  1'b0, 18'd0);
        probe("move 1,1",   10'd1,  9'd1,  1'b1, 18'd0);
        probe("move 50,50", 10'd50, 9'd50, 1'b1, 18'd2499);
        boundary();
        probe("move idle",  10'd51, 9'd1,  1'b0, 18'd0);
    endtask

    task automatic test_clamp();
        for (int f = 0; f < 589 + 5; f++) begin
            send_cmd(2'd0, OP_RIGHT, 8'd0, 1'b0);
            boundary();
        end
        probe("clamp 590,1",  10'd590, 9'd1,  1'b1, 18'd0);
        probe("clamp 639,50", 10'd639, 9'd50, 1'b1, 18'd2499);
        probe("clamp 589,1",  10'd589, 9'd1,  1'b0, 18'd0);
        probe("clamp 640,1",  10'd640, 9'd1,  1'b0, 18'd0);
        for (int f = 0; f < 2; f++) begin
            send_cmd(2'd0, OP_UP, 8'd0, 1'b0);
            boundary();
        end
        probe("clamp 590,0",  10'd590, 9'd0,  1'b1, 18'd0);
        probe("clamp 590,50", 10'd590, 9'd50, 1'b0, 18'd0);
    endtask

    task automatic test_overlap();
        send_cmd(2'd1, OP_ENABLE, 8'd0, 1'b0);
        send_cmd(2'd0, OP_HOME,   8'd0, 1'b0);
        send_cmd(2'd1, OP_HOME,   8'd0, 1'b0);
        boundary();
        probe("ovl spr1 home", 10'd50, 9'd0, 1'b1, 18'd2500);
        probe("ovl spr0 home", 10'd0,  9'd0, 1'b1, 18'd0);
        for (int f = 0; f < 10; f++) begin
            send_cmd(2'd1, OP_LEFT, 8'd0, 1'b0);
            boundary();
        end
        probe("ovl winner",   10'd45, 9'd3,  1'b1, 18'd195);
        probe("ovl spr1 only",10'd60, 9'd3,  1'b1, 18'd2670);
        probe("ovl spr1 end", 10'd89, 9'd49, 1'b1, 18'd4999);
        probe("ovl past",     10'd90, 9'd0,  1'b0, 18'd0);
    endtask

    task automatic test_enable();
        send_cmd(2'd1, OP_DISABLE, 8'd0, 1'b0);
        send_cmd(2'd1, OP_ENABLE,  8'd0, 1'b0);
        boundary();
        probe("en last enable",  10'd60, 9'd3, 1'b1, 18'd2670);
        send_cmd(2'd1, OP_ENABLE,  8'd0, 1'b0);
        send_cmd(2'd1, OP_DISABLE, 8'd0, 1'b0);
        boundary();
        probe("en last disable", 10'd60, 9'd3, 1'b0, 18'd0);
        send_cmd(2'd0, OP_LEFT,  8'd0, 1'b0);
        send_cmd(2'd0, OP_RIGHT, 8'd0, 1'b0);
        send_cmd(2'd0, OP_UP,    8'd0, 1'b0);
        boundary();
        probe("opposite no move", 10'd0, 9'd0, 1'b1, 18'd0);
    endtask

    task automatic test_glyph();
        send_cmd(2'd0, OP_SET, 8'd32,  1'b1);
        send_cmd(2'd0, OP_SET, 8'd127, 1'b1);
        boundary();
        probe("glyph unchanged", 10'd2, 9'd0, 1'b1, 18'd2);
        send_cmd(2'd0, OP_SET, 8'd126, 1'b0);
        send_cmd(2'd0, OP_SET, 8'd66,  1'b0);
        send_cmd(2'd0, OP_SET, 8'd65,  1'b0);
        boundary();
        probe("glyph 65 base", 10'd0, 9'd0, 1'b1, 18'd80000);
        probe("glyph 65 1,2",  10'd1, 9'd2, 1'b1, 18'd80101);
    endtask

    task automatic test_reset_mid();
        send_cmd(2'd0, OP_RIGHT, 8'd0, 1'b0);
        send_cmd(2'd1, OP_UP,    8'd0, 1'b0);
        probe("pre-reset hit",  10'd1,   9'd2,   1'b1, 18'd80101);
        probe("pre-reset miss", 10'd300, 9'd300, 1'b0, 18'd0);
        @(negedge clk);
        x = 10'd5; y = 9'd5; active_in = 1'b1; pix_en = 1'b1;
        #2 reset = 1'b0;
        #1 check_reset_outputs("mid reset");
        @(negedge clk);
        pix_en = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        boundary();
        probe("post-reset 3,4", 10'd3,  9'd4, 1'b1, 18'd203);
        probe("post-reset 0,0", 10'd0,  9'd0, 1'b1, 18'd0);
        probe("post-reset spr1",10'd60, 9'd3, 1'b0, 18'd0);
    endtask

    initial begin
        reset = 1'b0; pix_en = 1'b0; screen_end = 1'b0;
        x = '0; y = '0; active_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; bg_color = '0;
        cmd_bus.cmd_valid = 1'b0; cmd_bus.cmd_id = '0; cmd_bus.cmd_op = '0; cmd_bus.cmd_arg = '0;
        test_reset();
        test_scan();
        test_one_move();
        test_clamp();
        test_overlap();
        test_enable();
        test_glyph();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
